// File: rtl/latch_bank_pkg.sv
// Shared definitions for the latch-bank write controller.
//   state_e     : controller FSM state type
//   DEF_DATA_W  : default latch-bank word width
//   DEF_ADDR_W  : default register-select width (bank depth = 2**DEF_ADDR_W)
package latch_bank_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter (purely combinational).
//   req     : request bits, bit i = requester i
//   pointer : index of the requester granted most recently
//   grant   : one-hot grant, zero when req is zero
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       pointer,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Contention: the requester not served last wins.
      2'b11:   grant = pointer ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/latch_bank_ctrl.sv
// Write controller for a bank of level-sensitive latch words.
// Serves two requesters round-robin; each write runs IDLE -> SETUP -> STROBE -> HOLD so that
// lat_data is stable one cycle before and after the single-cycle enable pulse.
//   clk      : clock, all state changes on the rising edge
//   reset    : asynchronous active-low reset
//   req      : per-requester write request
//   addr0/1  : target word of requester 0/1
//   data0/1  : write data of requester 0/1
//   ack      : one-cycle write-complete pulse to the served requester
//   busy     : high while a write sequence is in progress
//   lat_en   : one-hot level enable, one bit per latch word
//   lat_data : shared data bus to the latch words
module latch_bank_ctrl
  import latch_bank_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req,
  input  logic [ADDR_W-1:0]      addr0,
  input  logic [ADDR_W-1:0]      addr1,
  input  logic [DATA_W-1:0]      data0,
  input  logic [DATA_W-1:0]      data1,
  output logic [1:0]             ack,
  output logic                   busy,
  output logic [2**ADDR_W-1:0]   lat_en,
  output logic [DATA_W-1:0]      lat_data
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  // Requester granted most recently: arbiter pointer and target of the HOLD ack.
  logic              last_q;
  logic [1:0]        grant;
  logic              capture;

  // Outputs are registered from the next state so the latch enables are glitch-free.
  logic [DEPTH-1:0]  lat_en_q, lat_en_d;
  logic [1:0]        ack_q, ack_d;
  logic              busy_q, busy_d;

  rr_arbiter2 u_arb (
    .req     (req),
    .pointer (last_q),
    .grant   (grant)
  );

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          state_d = SETUP;
          capture = 1'b1;
        end
      end
      SETUP:   state_d = STROBE;
      STROBE:  state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    lat_en_d = '0;
    if (state_d == STROBE) lat_en_d = DEPTH'(1) << addr_q;

    ack_d = 2'b00;
    if (state_d == HOLD) ack_d = last_q ? 2'b10 : 2'b01;

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      last_q   <= 1'b1;  // favours requester 0 on the first contention
      lat_en_q <= '0;
      ack_q    <= 2'b00;
      busy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        addr_q <= grant[0] ? addr0 : addr1;
        data_q <= grant[0] ? data0 : data1;
        last_q <= grant[1];
      end
      lat_en_q <= lat_en_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

  assign lat_en   = lat_en_q;
  assign ack      = ack_q;
  assign busy     = busy_q;
  assign lat_data = data_q;

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Self-checking bench for latch_bank_ctrl: directed scenarios plus randomized requesters,
// checked cycle by cycle against a transaction-level reference model.
module tb_latch_bank_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req = 2'b00;
  logic [2:0] addr0 = '0, addr1 = '0;
  logic [7:0] data0 = '0, data1 = '0;
  logic [1:0] ack;
  logic       busy;
  logic [7:0] lat_en;
  logic [7:0] lat_data;

  int n_tests = 0;
  int n_fail  = 0;

  latch_bank_ctrl #(
    .DATA_W (8),
    .ADDR_W (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .addr0    (addr0),
    .addr1    (addr1),
    .data0    (data0),
    .data1    (data1),
    .ack      (ack),
    .busy     (busy),
    .lat_en   (lat_en),
    .lat_data (lat_data)
  );

  always #5 clk = ~clk;

  // Behavioural latch bank: word i is transparent while lat_en[i] is high.
  logic [7:0] bank [8];
  always @(lat_en or lat_data) begin
    for (int i = 0; i < 8; i++) if (lat_en[i]) bank[i] = lat_data;
  end

  // Reference model: a write is a 4-cycle transaction (idle/setup/strobe/hold = phase 0..3).
  int         m_phase;
  logic       m_last;
  logic       m_win;
  logic [2:0] m_addr;
  logic [7:0] m_data;
  bit         auto_drop;
  int         served[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_last  = 1'b1;
    m_win   = 1'b0;
    m_addr  = '0;
    m_data  = '0;
  endtask

  // One clock: update the model with the inputs seen at the edge, then compare outputs.
  task automatic step();
    logic [1:0] r;
    logic [2:0] a0, a1;
    logic [7:0] d0, d1;
    r = req; a0 = addr0; a1 = addr1; d0 = data0; d1 = data1;
    @(posedge clk);
    if (m_phase == 0) begin
      if (r != 2'b00) begin
        if (r == 2'b11) m_win = ~m_last;
        else            m_win = r[1];
        m_last = m_win;
        m_addr = m_win ? a1 : a0;
        m_data = m_win ? d1 : d0;
        served.push_back(int'(m_win));
        m_phase = 1;
      end
    end else begin
      m_phase = (m_phase + 1) % 4;
    end
    #1;
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("lat_en", 32'(lat_en), (m_phase == 2) ? (32'd1 << m_addr) : 32'd0);
    check("ack", 32'(ack), (m_phase == 3) ? (32'd1 << m_win) : 32'd0);
    check("lat_data", 32'(lat_data), 32'(m_data));
    if (m_phase == 3) begin
      check("bank_word", 32'(bank[m_addr]), 32'(m_data));
      if (auto_drop) req[m_win] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = 2'b00;
    #2;
    check("rst_lat_en", 32'(lat_en), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_lat_data", 32'(lat_data), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    served.delete();
  endtask

  // Continuous protocol checks: enable is one-hot, data stable around every pulse.
  logic [7:0] prev_data = '0;
  logic [7:0] prev_en = '0;
  always @(negedge clk) begin
    if (reset) begin
      n_tests++;
      assert ($onehot0(lat_en)) else begin
        n_fail++;
        $error("FAIL onehot0: observed lat_en %0h expected at most one bit", lat_en);
      end
      if (lat_en != 0 || prev_en != 0) begin
        n_tests++;
        assert (lat_data === prev_data) else begin
          n_fail++;
          $error("FAIL data_stable: observed %0h expected %0h", lat_data, prev_data);
        end
      end
    end
    prev_data <= lat_data;
    prev_en   <= lat_en;
  end

  initial begin
    model_reset();
    auto_drop = 1'b1;
    do_reset();

    // Single write from requester 0.
    addr0 = 3'd5; data0 = 8'hA5; req = 2'b01;
    repeat (5) step();
    check("single_bank5", 32'(bank[5]), 32'hA5);
    check("single_count", 32'(served.size()), 32'd1);

    // Contention from reset: grants alternate starting with requester 0.
    do_reset();
    auto_drop = 1'b0;
    addr0 = 3'd1; data0 = 8'h11; addr1 = 3'd2; data1 = 8'h22; req = 2'b11;
    repeat (16) step();
    check("cont_count", 32'(served.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("cont_order", 32'(served[i]), 32'(i % 2));
    check("cont_bank1", 32'(bank[1]), 32'h11);
    check("cont_bank2", 32'(bank[2]), 32'h22);

    // Starvation: requester 1 held, requester 0 pulsed in every idle cycle.
    served.delete();
    addr0 = 3'd0; data0 = 8'h5F; addr1 = 3'd7; data1 = 8'hC3;
    repeat (24) begin
      req = {1'b1, 1'(m_phase == 0)};
      step();
    end
    check("starve_count", 32'(served.size() >= 5), 32'd1);
    for (int i = 1; i < served.size(); i++)
      check("starve_gap", 32'(served[i-1] == 0 && served[i] == 0), 32'd0);
    req = 2'b00;
    auto_drop = 1'b1;
    repeat (4) step();

    // Request dropped after one cycle still completes.
    served.delete();
    addr1 = 3'd7; data1 = 8'h3C; req = 2'b10;
    step();
    req = 2'b00;
    repeat (4) step();
    check("drop_count", 32'(served.size()), 32'd1);
    check("drop_bank7", 32'(bank[7]), 32'h3C);

    // Reset during STROBE aborts the write; pointer returns to favouring requester 0.
    addr0 = 3'd3; data0 = 8'h5A; req = 2'b01;
    step();
    req = 2'b00;
    step();
    do_reset();
    repeat (2) step();
    addr0 = 3'd4; data0 = 8'h44; addr1 = 3'd6; data1 = 8'h66; req = 2'b11;
    repeat (8) step();
    check("rst_fresh_count", 32'(served.size()), 32'd2);
    check("rst_fresh_first", 32'(served[0]), 32'd0);
    check("rst_fresh_second", 32'(served[1]), 32'd1);
    req = 2'b00;
    repeat (4) step();

    // Randomized requesters following the hold-until-ack protocol.
    auto_drop = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      if (!req[0] && $urandom_range(0, 2) == 0) begin
        addr0 = 3'($urandom); data0 = 8'($urandom); req[0] = 1'b1;
      end
      if (!req[1] && $urandom_range(0, 2) == 0) begin
        addr1 = 3'($urandom); data1 = 8'($urandom); req[1] = 1'b1;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
